ahb_flash_writer_shifter: RTL and testbench
===========================================

// Module: ahb_flash_writer_shifter
// PURPOSE
//  AHB-Lite slave that takes over the QSPI flash pins from the flash reader (FR) to program the flash.
//  Replaces per-pin bit-banging with a hardware byte shifter: SPI mode 0, single or quad I/O, programmable SCK divider.
//  Software gates the takeover with a keyed write-enable, then selects the flash with SS.
//  Each write to TX shifts one byte out and one byte in. Sits between FR and the flash pads.
// PARAMETERS
//  DIV_W     8              width of CLKDIV field; SCK half-period = CLKDIV+1 HCLK cycles
//  DIV_RST   1              reset value of CLKDIV
//  ID_VALUE  32'hABCD0002   value returned by ID register
// PORTS
//  HCLK       in   1   clock
//  HRESETn    in   1   asynchronous, active-low reset
//  HSEL,HADDR[31:0],HTRANS[1:0],HWRITE,HREADY,HWDATA[31:0],HSIZE[2:0]  in   AHB-Lite slave inputs
//  HREADYOUT  out  1   tied 1; zero wait states
//  HRDATA     out  32  read data, valid in the data phase
//  fr_sck,fr_ce_n,fr_dout[3:0],fr_douten   in   FR-side flash signals
//  fr_din     out  4   always equals fm_din
//  fm_sck,fm_ce_n,fm_dout[3:0],fm_douten[3:0]  out  flash pins: FR passthrough when WE=0, shifter when WE=1
//  fm_din     in   4   flash IO inputs
// BEHAVIOUR
//  AHB: address/control latched when HSEL&HREADY&HTRANS[1]. Writes take effect in the data phase using HWDATA.
//  Only HADDR[7:0] is decoded. Unmapped offsets read 0; writes to them are ignored.
//  00 WE:   written only if HWDATA[31:8]==24'hA5A855; then WE<=HWDATA[0]. Reset 0. Reads {31'b0,WE}.
//  04 SS:   bit0 drives ce_n. Reset 1.
//  08 CTRL: [DIV_W-1:0] CLKDIV (reset DIV_RST); [16] QUAD (reset 0); [17] QDIR (1=quad write, 0=quad read; reset 0).
//  0C TX:   write [7:0]. If idle and WE=1, loads the shifter and sets BUSY on the next cycle.
//           If BUSY, the write is dropped and OVR is set. If WE=0, the write is ignored.
//  10 RX:   [7:0] last completed received byte. Reset 0. Updated only when a transfer completes.
//  14 STAT: [0] BUSY (read-only); [1] OVR (sticky; write 1 clears). Set has priority over a same-cycle clear.
//  18 ID:   ID_VALUE.
//  FSM IDLE -> LOW -> HIGH -> LOW ... -> IDLE. A divider counter runs CLKDIV+1 cycles per state.
//   - IDLE: sck=0. A TX write enters LOW with MSB bits on dout and bitcnt = 8 (single) or 2 (quad).
//   - LOW->HIGH: sck rises; din captured into rx shift: single fm_din[1], quad fm_din[3:0].
//   - HIGH end: bitcnt-=1 (single) or -=1 per nibble (quad).
//     If bitcnt==0: go IDLE, sck=0, RX<=rx shift, BUSY clears. Else shift next bit/nibble out and go LOW.
//   - Byte time: 16*(CLKDIV+1) HCLK (single), 4*(CLKDIV+1) HCLK (quad), from TX data phase to BUSY=0.
//   - CLKDIV and QUAD are sampled at transfer start. Changes during BUSY do not affect the current byte.
//  Pin drive when WE=1:
//   - single: fm_dout={2'b11,1'b0,tx[7]}, douten=4'b1101 (IO2/IO3 held high as WP#/HOLD#).
//   - quad:   fm_dout=tx[7:4] nibble, douten=QDIR?4'hF:4'h0.
//   - fm_sck=shifter sck; fm_ce_n=SS.
//  WE=0: fm_sck=fr_sck, fm_ce_n=fr_ce_n, fm_dout=fr_dout, fm_douten={4{fr_douten}}.
//  WE cleared while BUSY: transfer aborts the next cycle. FSM goes IDLE, sck=0, BUSY=0, RX unchanged, pins revert to FR.
//  Reset (any time): WE=0, SS=1, CLKDIV=DIV_RST, QUAD=0, QDIR=0, RX=0, BUSY=0, OVR=0, FSM IDLE, sck=0.
//   Outputs therefore pass FR signals through after reset.
// TESTING
//  1 Reset, then drive fr_sck/fr_ce_n/fr_dout=4'hA/fr_douten=1 -> fm_* mirror them, fm_douten=4'hF, ID reads 32'hABCD0002.
//  2 Write 0x12345601 to WE -> WE stays 0. Write 0xA5A85501 -> WE=1, fm_ce_n=SS=1. Clear SS -> fm_ce_n=0.
//  3 CLKDIV=1, single, TX=0x9F, fm_din[1] scripted 0xC2 -> 8 rising edges, MSB-first 1,0,0,1,1,1,1,1 on fm_dout[0].
//    BUSY clears 32 cycles after the TX data phase; RX=0xC2.
//  4 QUAD=1, QDIR=1, CLKDIV=0, TX=0x5A -> fm_douten=4'hF, nibbles 5 then A over 2 SCK, BUSY high 4 cycles.
//    Repeat with QDIR=0, fm_din nibbles 3,C -> RX=0x3C.
//  5 TX write while BUSY -> dropped, OVR=1, current byte unaffected. Write STAT=2 -> OVR=0.
//  6 Mid-byte WE write with key+0 -> sck=0, BUSY=0 next cycle, pins back to FR. Async HRESETn mid-byte -> all reset values.

Source files
------------

// File: rtl/ahb_flash_writer_shifter_if.sv
// AHB-Lite slave-side bus bundle for the flash writer/shifter.
// The master modport is what a bus fabric (or bench) drives; the slave modport is the block's view.
interface ahb_flash_writer_shifter_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic        HREADY;
  logic [31:0] HWDATA;
  logic [2:0]  HSIZE;
  logic        HREADYOUT;
  logic [31:0] HRDATA;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HREADY, HWDATA, HSIZE,
    input  HREADYOUT, HRDATA
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HREADY, HWDATA, HSIZE,
    output HREADYOUT, HRDATA
  );
endinterface

// File: rtl/ahb_flash_writer_shifter.sv
// AHB-Lite flash programming bridge: passes the flash reader through to the pads, or, once
// unlocked by a keyed write-enable, drives them from an SPI mode-0 single/quad byte shifter.
module ahb_flash_writer_shifter #(
  parameter int unsigned DIV_W    = 8,
  parameter int unsigned DIV_RST  = 1,
  parameter logic [31:0] ID_VALUE = 32'hABCD0002
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  ahb_flash_writer_shifter_if.slave ahb,
  input  logic                      fr_sck,
  input  logic                      fr_ce_n,
  input  logic [3:0]                fr_dout,
  input  logic                      fr_douten,
  output logic [3:0]                fr_din,
  output logic                      fm_sck,
  output logic                      fm_ce_n,
  output logic [3:0]                fm_dout,
  output logic [3:0]                fm_douten,
  input  logic [3:0]                fm_din
);

  localparam logic [7:0]  OFF_WE   = 8'h00;
  localparam logic [7:0]  OFF_SS   = 8'h04;
  localparam logic [7:0]  OFF_CTRL = 8'h08;
  localparam logic [7:0]  OFF_TX   = 8'h0C;
  localparam logic [7:0]  OFF_RX   = 8'h10;
  localparam logic [7:0]  OFF_STAT = 8'h14;
  localparam logic [7:0]  OFF_ID   = 8'h18;
  localparam logic [23:0] WE_KEY   = 24'hA5A855;

  typedef enum logic [1:0] {ST_IDLE, ST_LOW, ST_HIGH} state_e;
  typedef logic [DIV_W-1:0] div_t;

  logic       vld_q, vld_d, wr_q, wr_d;
  logic [7:0] addr_q, addr_d;
  logic       we_q, we_d, ss_q, ss_d;
  div_t       div_q, div_d;
  logic       quad_q, quad_d, qdir_q, qdir_d;
  logic [7:0] rx_q, rx_d;
  logic       ovr_q, ovr_d;
  state_e     state_q, state_d;
  div_t       cnt_q, cnt_d;
  logic [3:0] bitcnt_q, bitcnt_d;
  logic [7:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;
  logic       sck_q, sck_d;
  logic       quad_act_q, quad_act_d;
  div_t       div_act_q, div_act_d;

  logic        busy, wr_en, tx_start, ovr_set, ovr_clr, quad_sel;
  logic [31:0] rdata, ctrl_rd;
  logic        unused_ok;

  assign busy          = (state_q != ST_IDLE);
  assign wr_en         = vld_q & wr_q;
  assign ahb.HREADYOUT = 1'b1;
  assign ahb.HRDATA    = rdata;
  assign fr_din        = fm_din;
  assign unused_ok     = &{1'b0, ahb.HSIZE, ahb.HADDR[31:8], ahb.HTRANS[0]};

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    vld_d      = ahb.HSEL & ahb.HREADY & ahb.HTRANS[1];
    addr_d     = vld_d ? ahb.HADDR[7:0] : addr_q;
    wr_d       = vld_d ? ahb.HWRITE : wr_q;
    we_d       = we_q;
    ss_d       = ss_q;
    div_d      = div_q;
    quad_d     = quad_q;
    qdir_d     = qdir_q;
    rx_d       = rx_q;
    tx_start   = 1'b0;
    ovr_set    = 1'b0;
    ovr_clr    = 1'b0;

    if (wr_en) begin
      case (addr_q)
        OFF_WE:   if (ahb.HWDATA[31:8] == WE_KEY) we_d = ahb.HWDATA[0];
        OFF_SS:   ss_d = ahb.HWDATA[0];
        OFF_CTRL: begin
          div_d  = ahb.HWDATA[DIV_W-1:0];
          quad_d = ahb.HWDATA[16];
          qdir_d = ahb.HWDATA[17];
        end
        OFF_TX:   if (we_q) begin
          if (busy) ovr_set  = 1'b1;
          else      tx_start = 1'b1;
        end
        OFF_STAT: ovr_clr = ahb.HWDATA[1];
        default:  ;
      endcase
    end
    ovr_d = (ovr_q & ~ovr_clr) | ovr_set;

    state_d    = state_q;
    cnt_d      = cnt_q;
    bitcnt_d   = bitcnt_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    sck_d      = sck_q;
    quad_act_d = quad_act_q;
    div_act_d  = div_act_q;

    // Losing write-enable parks the shifter immediately, mid-byte or not.
    if (!we_q) begin
      state_d = ST_IDLE;
      sck_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (tx_start) begin
          state_d    = ST_LOW;
          cnt_d      = '0;
          bitcnt_d   = quad_q ? 4'd2 : 4'd8;
          tx_sh_d    = ahb.HWDATA[7:0];
          quad_act_d = quad_q;
          div_act_d  = div_q;
          sck_d      = 1'b0;
        end
        ST_LOW: begin
          if (cnt_q == div_act_q) begin
            cnt_d   = '0;
            state_d = ST_HIGH;
            sck_d   = 1'b1;
            rx_sh_d = quad_act_q ? {rx_sh_q[3:0], fm_din} : {rx_sh_q[6:0], fm_din[1]};
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_HIGH: begin
          if (cnt_q == div_act_q) begin
            cnt_d    = '0;
            sck_d    = 1'b0;
            bitcnt_d = bitcnt_q - 4'd1;
            if (bitcnt_q == 4'd1) begin
              state_d = ST_IDLE;
              rx_d    = rx_sh_q;
            end else begin
              state_d = ST_LOW;
              tx_sh_d = quad_act_q ? {tx_sh_q[3:0], 4'h0} : {tx_sh_q[6:0], 1'b0};
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    ctrl_rd                = '0;
    ctrl_rd[DIV_W-1:0]     = div_q;
    ctrl_rd[16]            = quad_q;
    ctrl_rd[17]            = qdir_q;
    rdata                  = '0;
    if (vld_q && !wr_q) begin
      case (addr_q)
        OFF_WE:   rdata = {31'b0, we_q};
        OFF_SS:   rdata = {31'b0, ss_q};
        OFF_CTRL: rdata = ctrl_rd;
        OFF_RX:   rdata = {24'b0, rx_q};
        OFF_STAT: rdata = {30'b0, ovr_q, busy};
        OFF_ID:   rdata = ID_VALUE;
        default:  rdata = '0;
      endcase
    end
  end

  // Lane mode follows the latched transfer mode while busy so a CTRL rewrite cannot glitch the pads.
  always_comb begin
    quad_sel = busy ? quad_act_q : quad_q;
    if (we_q) begin
      fm_sck  = sck_q;
      fm_ce_n = ss_q;
      if (quad_sel) begin
        fm_dout   = tx_sh_q[7:4];
        fm_douten = {4{qdir_q}};
      end else begin
        fm_dout   = {3'b110, tx_sh_q[7]};
        fm_douten = 4'b1101;
      end
    end else begin
      fm_sck    = fr_sck;
      fm_ce_n   = fr_ce_n;
      fm_dout   = fr_dout;
      fm_douten = {4{fr_douten}};
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      vld_q      <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      ss_q       <= 1'b1;
      div_q      <= div_t'(DIV_RST);
      quad_q     <= 1'b0;
      qdir_q     <= 1'b0;
      rx_q       <= '0;
      ovr_q      <= 1'b0;
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      bitcnt_q   <= '0;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      sck_q      <= 1'b0;
      quad_act_q <= 1'b0;
      div_act_q  <= '0;
    end else begin
      vld_q      <= vld_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      ss_q       <= ss_d;
      div_q      <= div_d;
      quad_q     <= quad_d;
      qdir_q     <= qdir_d;
      rx_q       <= rx_d;
      ovr_q      <= ovr_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bitcnt_q   <= bitcnt_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      sck_q      <= sck_d;
      quad_act_q <= quad_act_d;
      div_act_q  <= div_act_d;
    end
  end

endmodule

// File: tb/tb_ahb_flash_writer_shifter.sv
// Self-checking bench: directed register/pin checks plus randomized byte transfers
// scored against an edge-level model of what the flash should see and return.
module tb_ahb_flash_writer_shifter;

  localparam logic [7:0]  A_WE   = 8'h00;
  localparam logic [7:0]  A_SS   = 8'h04;
  localparam logic [7:0]  A_CTRL = 8'h08;
  localparam logic [7:0]  A_TX   = 8'h0C;
  localparam logic [7:0]  A_RX   = 8'h10;
  localparam logic [7:0]  A_STAT = 8'h14;
  localparam logic [7:0]  A_ID   = 8'h18;
  localparam logic [23:0] KEY    = 24'hA5A855;

  logic       HCLK = 1'b0;
  logic       HRESETn = 1'b0;
  logic       fr_sck, fr_ce_n, fr_douten;
  logic [3:0] fr_dout, fr_din;
  logic       fm_sck, fm_ce_n;
  logic [3:0] fm_dout, fm_douten, fm_din;

  int checks = 0;
  int errors = 0;
  logic [31:0] rd;
  logic [7:0]  last_rx = 8'h00;

  ahb_flash_writer_shifter_if ahb ();

  ahb_flash_writer_shifter dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .ahb       (ahb),
    .fr_sck    (fr_sck),
    .fr_ce_n   (fr_ce_n),
    .fr_dout   (fr_dout),
    .fr_douten (fr_douten),
    .fr_din    (fr_din),
    .fm_sck    (fm_sck),
    .fm_ce_n   (fm_ce_n),
    .fm_dout   (fm_dout),
    .fm_douten (fm_douten),
    .fm_din    (fm_din)
  );

  always #5 HCLK = ~HCLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic bus_idle();
    ahb.HSEL   = 1'b0;
    ahb.HTRANS = 2'b00;
    ahb.HWRITE = 1'b0;
  endtask

  task automatic addr_phase(input logic [7:0] a, input logic wr);
    ahb.HSEL   = 1'b1;
    ahb.HTRANS = 2'b10;
    ahb.HWRITE = wr;
    ahb.HREADY = 1'b1;
    ahb.HSIZE  = 3'b010;
    ahb.HADDR  = ($urandom() & 32'hFFFF_FF00) | {24'h0, a};
  endtask

  task automatic ahb_write(input logic [7:0] a, input logic [31:0] d);
    @(posedge HCLK); #1;
    addr_phase(a, 1'b1);
    @(posedge HCLK); #1;
    bus_idle();
    ahb.HWDATA = d;
  endtask

  task automatic ahb_read(input logic [7:0] a, output logic [31:0] d);
    @(posedge HCLK); #1;
    addr_phase(a, 1'b0);
    @(posedge HCLK); #1;
    bus_idle();
    d = ahb.HRDATA;
  endtask

  task automatic wait_idle(input string tag);
    logic [31:0] s;
    s = 32'h1;
    for (int i = 0; i < 500 && s[0]; i++) ahb_read(A_STAT, s);
    check(tag, {31'b0, s[0]}, 32'h0);
  endtask

  task automatic check_passthrough(input string tag);
    #1;
    check({tag, "_sck"},  {31'b0, fm_sck},  {31'b0, fr_sck});
    check({tag, "_ce"},   {31'b0, fm_ce_n}, {31'b0, fr_ce_n});
    check({tag, "_dout"}, {28'b0, fm_dout}, {28'b0, fr_dout});
    check({tag, "_oe"},   {28'b0, fm_douten}, {28'b0, {4{fr_douten}}});
  endtask

  // One byte: the bench plays the flash, driving din after each falling SCK edge and
  // recording dout at each rising edge, while STAT is polled every cycle for BUSY.
  task automatic xfer(input string tag, input logic [7:0] tx, input logic [7:0] rxb,
                      input int div, input bit quad, input bit qdir);
    int busy_cnt, edges, din_idx, pin_bad, exp_busy, exp_edges;
    logic [7:0] obs;
    logic [3:0] exp_oe;
    logic prev;
    ahb_write(A_CTRL, (32'(qdir) << 17) | (32'(quad) << 16) | 32'(div));
    fm_din = quad ? rxb[7:4] : {2'b00, rxb[7], 1'b0};
    @(posedge HCLK); #1;
    addr_phase(A_TX, 1'b1);
    @(posedge HCLK); #1;
    ahb.HWDATA = {$urandom_range(0, 255) << 8} | {24'h0, tx};
    addr_phase(A_STAT, 1'b0);
    busy_cnt = 0; edges = 0; din_idx = 1; pin_bad = 0; obs = 8'h00;
    exp_oe = quad ? (qdir ? 4'hF : 4'h0) : 4'b1101;
    prev = fm_sck;
    for (int c = 0; c < 2000; c++) begin
      @(posedge HCLK); #1;
      if (fm_sck && !prev) begin
        edges++;
        obs = quad ? {obs[3:0], fm_dout} : {obs[6:0], fm_dout[0]};
        if (fm_douten !== exp_oe || (!quad && fm_dout[3:1] !== 3'b110)) pin_bad++;
      end
      if (!fm_sck && prev && din_idx < (quad ? 2 : 8)) begin
        if (quad) fm_din = rxb[3:0];
        else      fm_din[1] = rxb[7 - din_idx];
        din_idx++;
      end
      prev = fm_sck;
      if (ahb.HRDATA[0]) busy_cnt++;
      else break;
    end
    bus_idle();
    exp_busy  = (quad ? 4 : 16) * (div + 1);
    exp_edges = quad ? 2 : 8;
    check({tag, "_busy_cycles"}, busy_cnt, exp_busy);
    check({tag, "_sck_edges"}, edges, exp_edges);
    check({tag, "_dout_bits"}, {24'b0, obs}, {24'b0, tx});
    check({tag, "_pin_drive"}, pin_bad, 0);
    check({tag, "_sck_idle"}, {31'b0, fm_sck}, 32'h0);
    ahb_read(A_RX, rd);
    check({tag, "_rx"}, rd, {24'b0, rxb});
    last_rx = rxb;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_idle();
    ahb.HREADY = 1'b1; ahb.HADDR = '0; ahb.HWDATA = '0; ahb.HSIZE = 3'b010;
    fr_sck = 1'b1; fr_ce_n = 1'b0; fr_dout = 4'hA; fr_douten = 1'b1; fm_din = 4'h0;
    #22 HRESETn = 1'b1;

    // Reset state and FR passthrough
    check_passthrough("rst_pass");
    check("rst_fr_din", {28'b0, fr_din}, {28'b0, fm_din});
    ahb_read(A_ID, rd);   check("id", rd, 32'hABCD0002);
    ahb_read(A_WE, rd);   check("rst_we", rd, 32'h0);
    ahb_read(A_SS, rd);   check("rst_ss", rd, 32'h1);
    ahb_read(A_CTRL, rd); check("rst_ctrl", rd, 32'h1);
    ahb_read(A_RX, rd);   check("rst_rx", rd, 32'h0);
    ahb_read(A_STAT, rd); check("rst_stat", rd, 32'h0);
    ahb_read(8'h1C, rd);  check("unmapped", rd, 32'h0);
    for (int i = 0; i < 4; i++) begin
      fr_sck = 1'($urandom); fr_ce_n = 1'($urandom); fr_dout = 4'($urandom);
      fr_douten = 1'($urandom); fm_din = 4'($urandom);
      check_passthrough("rnd_pass");
      check("rnd_fr_din", {28'b0, fr_din}, {28'b0, fm_din});
    end
    ahb_write(A_CTRL, 32'hFFFF_FFFF);
    ahb_read(A_CTRL, rd); check("ctrl_rw", rd, 32'h0003_00FF);

    // Keyed write-enable and SS
    fr_sck = 1'b1; fr_ce_n = 1'b0;
    ahb_write(A_TX, 32'h55);
    ahb_read(A_STAT, rd); check("tx_ignored_we0", rd, 32'h0);
    ahb_write(A_WE, 32'h1234_5601);
    ahb_read(A_WE, rd); check("we_badkey", rd, 32'h0);
    ahb_write(A_WE, {KEY, 8'h01});
    ahb_read(A_WE, rd); check("we_goodkey", rd, 32'h1);
    check("we_ce_ss1", {31'b0, fm_ce_n}, 32'h1);
    check("we_sck0", {31'b0, fm_sck}, 32'h0);
    ahb_write(A_CTRL, 32'h0);
    @(posedge HCLK); #1;
    check("we_single_oe", {28'b0, fm_douten}, 32'hD);
    ahb_write(A_SS, 32'h0);
    @(posedge HCLK); #1;
    check("ss_ce0", {31'b0, fm_ce_n}, 32'h0);

    // Directed transfers
    xfer("single_9f", 8'h9F, 8'hC2, 1, 1'b0, 1'b0);
    xfer("quad_wr",   8'h5A, 8'h00, 0, 1'b1, 1'b1);
    xfer("quad_rd",   8'h77, 8'h3C, 0, 1'b1, 1'b0);

    // Randomized transfers
    for (int i = 0; i < 12; i++)
      xfer("rnd", 8'($urandom), 8'($urandom), int'($urandom_range(0, 3)),
           1'($urandom), 1'($urandom));

    // Overrun while busy
    fm_din = 4'hF;
    ahb_write(A_CTRL, 32'h3);
    ahb_write(A_TX, 32'h81);
    ahb_write(A_TX, 32'h42);
    ahb_read(A_STAT, rd); check("ovr_set", rd, 32'h3);
    wait_idle("ovr_idle");
    ahb_read(A_RX, rd); check("ovr_rx", rd, 32'hFF);
    last_rx = 8'hFF;
    ahb_read(A_STAT, rd); check("ovr_sticky", rd, 32'h2);
    ahb_write(A_STAT, 32'h2);
    ahb_read(A_STAT, rd); check("ovr_clear", rd, 32'h0);

    // Abort by clearing WE mid-byte
    fr_sck = 1'b1; fr_ce_n = 1'b1; fr_dout = 4'h6; fr_douten = 1'b0;
    fm_din = 4'h0;
    ahb_write(A_TX, 32'h3C);
    repeat (10) @(posedge HCLK);
    ahb_write(A_WE, {KEY, 8'h00});
    @(posedge HCLK);
    check_passthrough("abort_pass");
    ahb_read(A_STAT, rd); check("abort_stat", rd, 32'h0);
    ahb_read(A_RX, rd);   check("abort_rx", rd, {24'b0, last_rx});
    ahb_write(A_WE, {KEY, 8'h01});
    ahb_read(A_STAT, rd); check("abort_busy0", rd, 32'h0);
    check("abort_sck0", {31'b0, fm_sck}, 32'h0);

    // Asynchronous reset mid-byte
    ahb_write(A_CTRL, 32'h0003_0005);
    ahb_write(A_TX, 32'hE7);
    repeat (5) @(posedge HCLK);
    #3 HRESETn = 1'b0;
    check_passthrough("arst_pass");
    #10 HRESETn = 1'b1;
    ahb_read(A_WE, rd);   check("arst_we", rd, 32'h0);
    ahb_read(A_SS, rd);   check("arst_ss", rd, 32'h1);
    ahb_read(A_CTRL, rd); check("arst_ctrl", rd, 32'h1);
    ahb_read(A_RX, rd);   check("arst_rx", rd, 32'h0);
    ahb_read(A_STAT, rd); check("arst_stat", rd, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
